// File: rtl/nco_pkg.sv
// Shared types and the quarter-wave phase fold for the NCO sine path.
package nco_pkg;

    localparam int PHASE_W  = 8;
    localparam int QTR_AW   = 6;
    localparam int DATA_W   = 16;
    localparam int TAG_CH_W = 3;
    localparam logic [DATA_W-1:0] FULL_SCALE = 16'h7FFF;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_e;

    typedef struct packed {
        logic [QTR_AW-1:0] addr;
        logic              sign;
        logic              fullscale;
    } fold_t;

    typedef struct packed {
        logic [TAG_CH_W-1:0] ch;
        logic                sign;
        logic                fullscale;
        logic                valid;
    } pipe_tag_t;

    function automatic fold_t fold_phase(input logic [PHASE_W-1:0] phase);
        quadrant_e         q;
        logic [QTR_AW-1:0] idx;
        logic              odd_q;
        fold_t             f;
        q     = quadrant_e'(phase[PHASE_W-1 -: 2]);
        idx   = phase[QTR_AW-1:0];
        odd_q = (q == Q1) || (q == Q3);
        f.sign = (q == Q2) || (q == Q3);
        // 64-idx in 6 bits; the idx==0 peak is outside the table and bypasses the ROM
        f.addr      = odd_q ? (QTR_AW'(0) - idx) : idx;
        f.fullscale = odd_q && (idx == '0);
        return f;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at a rotating pointer.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_vld
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand_idx;
    int unsigned      cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = 32'(ptr_q) + 32'(i);
            if (cand >= 32'(NUM_CH)) cand = cand - 32'(NUM_CH);
            cand_idx = IDX_W'(cand);
            if (!grant_vld && req[cand_idx]) begin
                grant_vld        = 1'b1;
                grant[cand_idx]  = 1'b1;
                grant_idx        = cand_idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/sine_rom_arbiter.sv
// Shares one quarter-wave sine ROM among NUM_CH NCO channels with a fixed
// three-cycle accept-to-response pipeline.
module sine_rom_arbiter
    import nco_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         req_valid,
    input  logic [NUM_CH*PHASE_W-1:0] req_phase,
    output logic [NUM_CH-1:0]         req_ready,
    output logic                      rom_en,
    output logic [QTR_AW-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      rsp_valid,
    output logic [CH_W-1:0]           rsp_ch,
    output logic [DATA_W-1:0]         rsp_data
);

    logic [NUM_CH-1:0]  grant;
    logic [CH_W-1:0]    grant_idx;
    logic               grant_vld;
    logic               accept;
    logic [PHASE_W-1:0] acc_phase;
    fold_t              acc_fold;

    pipe_tag_t          tag_a_q, tag_a_d, tag_b_q, tag_b_d;
    logic               rom_en_q, rom_en_d;
    logic [QTR_AW-1:0]  rom_addr_q, rom_addr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [CH_W-1:0]    rsp_ch_q, rsp_ch_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic [DATA_W-1:0]  mag;
    logic               unused_tag_ch;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CH_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst),
        .req       (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // Grant is purely combinational, so it must be masked while reset is held
    assign req_ready = rst ? grant : '0;
    assign accept    = rst & grant_vld;
    assign acc_phase = req_phase[int'(grant_idx) * PHASE_W +: PHASE_W];
    assign acc_fold  = fold_phase(acc_phase);

    always_comb begin
        tag_a_d           = '0;
        tag_a_d.ch        = TAG_CH_W'(grant_idx);
        tag_a_d.sign      = acc_fold.sign;
        tag_a_d.fullscale = acc_fold.fullscale;
        tag_a_d.valid     = accept;
        rom_en_d          = accept & ~acc_fold.fullscale;
        rom_addr_d        = accept ? acc_fold.addr : rom_addr_q;
        tag_b_d           = tag_a_q;
    end

    always_comb begin
        mag         = tag_b_q.fullscale ? FULL_SCALE : rom_data;
        rsp_valid_d = tag_b_q.valid;
        rsp_ch_d    = rsp_ch_q;
        rsp_data_d  = rsp_data_q;
        if (tag_b_q.valid) begin
            rsp_ch_d   = tag_b_q.ch[CH_W-1:0];
            rsp_data_d = tag_b_q.sign ? ('0 - mag) : mag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_a_q     <= '0;
            tag_b_q     <= '0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ch_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            tag_a_q     <= tag_a_d;
            tag_b_q     <= tag_b_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ch_q    <= rsp_ch_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rom_en        = rom_en_q;
    assign rom_addr      = rom_addr_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_ch        = rsp_ch_q;
    assign rsp_data      = rsp_data_q;
    assign unused_tag_ch = ^tag_b_q.ch;

endmodule

// File: tb/tb_sine_rom_arbiter.sv
// Bench for sine_rom_arbiter: external registered ROM model, a sine-based
// reference with a response queue, table vectors and random traffic.
module tb_sine_rom_arbiter;

    localparam int NUM_CH = 4;
    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_phase;
    logic [3:0]  req_ready;
    logic        rom_en;
    logic [5:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic        rsp_valid;
    logic [1:0]  rsp_ch;
    logic [15:0] rsp_data;

    always #5 clk = ~clk;

    sine_rom_arbiter #(.NUM_CH(NUM_CH), .CH_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_phase (req_phase),
        .req_ready (req_ready),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rsp_valid (rsp_valid),
        .rsp_ch    (rsp_ch),
        .rsp_data  (rsp_data)
    );

    logic [15:0] rom_tbl [64];
    always @(posedge clk) if (rom_en) rom_data <= rom_tbl[rom_addr];

    typedef struct {
        int          due;
        int          ch;
        logic [15:0] data;
    } exp_rsp_t;

    typedef struct {
        int          ch;
        logic [7:0]  phase;
        logic        en;
        logic [5:0]  addr;
        logic [15:0] data;
    } vec_t;

    exp_rsp_t    exp_q[$];
    vec_t        vecs[14];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          mdl_ptr;
    int          mdl_gnt;
    logic        mdl_rom_en;
    logic [5:0]  mdl_rom_addr;
    int          last_ch;
    logic [15:0] last_data;

    function automatic logic [15:0] golden(input int p);
        real s;
        int  r;
        s = 32767.0 * $sin(2.0 * PI * p / 256.0);
        if (s >= 0.0) r = $rtoi(s + 0.5);
        else          r = -$rtoi(-s + 0.5);
        return 16'(r);
    endfunction

    function automatic int fold_addr(input int p);
        int quad, idx;
        quad = p / 64;
        idx  = p % 64;
        return (quad % 2 == 1) ? (64 - idx) % 64 : idx;
    endfunction

    function automatic bit is_bypass(input int p);
        return ((p / 64) % 2 == 1) && (p % 64 == 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mdl_ptr      = 0;
        mdl_gnt      = -1;
        mdl_rom_en   = 1'b0;
        mdl_rom_addr = '0;
        last_ch      = 0;
        last_data    = '0;
        exp_q.delete();
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step(input bit rst_after);
        int         g, c, p;
        logic [3:0] exp_ready;
        exp_rsp_t   e;
        if (!rst) model_reset();
        #1;
        g = -1;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                c = (mdl_ptr + i) % NUM_CH;
                if (g < 0 && req_valid[c]) g = c;
            end
        end
        exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        mdl_gnt = g;
        @(posedge clk);
        if (g >= 0) begin
            p = int'(req_phase[g*8 +: 8]);
            e.due  = cyc + 3;
            e.ch   = g;
            e.data = golden(p);
            exp_q.push_back(e);
            mdl_ptr      = (g + 1) % NUM_CH;
            mdl_rom_en   = !is_bypass(p);
            mdl_rom_addr = 6'(fold_addr(p));
        end else begin
            mdl_rom_en = 1'b0;
        end
        cyc++;
        if (rst_after) begin
            #1;
            rst = 1'b0;
            model_reset();
        end
        @(negedge clk);
        check("rom_en", 32'(rom_en), 32'(mdl_rom_en));
        if (mdl_rom_en) check("rom_addr", 32'(rom_addr), 32'(mdl_rom_addr));
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check("rsp_valid", 32'(rsp_valid), 32'd1);
            check("rsp_ch", 32'(rsp_ch), 32'(exp_q[0].ch));
            check("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
            last_ch   = exp_q[0].ch;
            last_data = exp_q[0].data;
            void'(exp_q.pop_front());
        end else begin
            check("rsp_idle_valid", 32'(rsp_valid), 32'd0);
            check("rsp_hold_ch", 32'(rsp_ch), 32'(last_ch));
            check("rsp_hold_data", 32'(rsp_data), 32'(last_data));
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(1'b0);
        step(1'b0);
        rst = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 64; k++) rom_tbl[k] = golden(k);
        // ch, phase, rom_en, rom_addr, signed sample
        vecs[0]  = '{0, 8'h40, 1'b0, 6'h00, 16'h7FFF};
        vecs[1]  = '{1, 8'h00, 1'b1, 6'h00, 16'h0000};
        vecs[2]  = '{2, 8'h41, 1'b1, 6'h3F, 16'h7FF5};
        vecs[3]  = '{3, 8'hC1, 1'b1, 6'h3F, 16'h800B};
        vecs[4]  = '{0, 8'h20, 1'b1, 6'h20, 16'h5A82};
        vecs[5]  = '{1, 8'h60, 1'b1, 6'h20, 16'h5A82};
        vecs[6]  = '{2, 8'hA0, 1'b1, 6'h20, 16'hA57E};
        vecs[7]  = '{3, 8'hE0, 1'b1, 6'h20, 16'hA57E};
        vecs[8]  = '{0, 8'h80, 1'b1, 6'h00, 16'h0000};
        vecs[9]  = '{1, 8'hC0, 1'b0, 6'h00, 16'h8001};
        vecs[10] = '{2, 8'h01, 1'b1, 6'h01, 16'h0324};
        vecs[11] = '{3, 8'h81, 1'b1, 6'h01, 16'hFCDC};
        vecs[12] = '{0, 8'hBF, 1'b1, 6'h3F, 16'h800B};
        vecs[13] = '{1, 8'hFF, 1'b1, 6'h01, 16'hFCDC};

        model_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_phase = 32'h1234_5678;
        #1 rst = 1'b0;
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_rom_en", 32'(rom_en), 32'd0);
        check("reset_rom_addr", 32'(rom_addr), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_ch", 32'(rsp_ch), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        @(negedge clk);
        step(1'b0);
        req_valid = '0;
        rst = 1'b1;

        for (int v = 0; v < 14; v++) begin
            req_valid = 4'(1 << vecs[v].ch);
            req_phase[vecs[v].ch*8 +: 8] = vecs[v].phase;
            step(1'b0);
            check("vec_rom_en", 32'(rom_en), 32'(vecs[v].en));
            if (vecs[v].en) check("vec_rom_addr", 32'(rom_addr), 32'(vecs[v].addr));
            req_valid = '0;
            step(1'b0);
            step(1'b0);
            check("vec_rsp_valid", 32'(rsp_valid), 32'd1);
            check("vec_rsp_ch", 32'(rsp_ch), 32'(vecs[v].ch));
            check("vec_rsp_data", 32'(rsp_data), 32'(vecs[v].data));
        end

        do_reset();
        req_phase = {8'hC0, 8'h80, 8'h20, 8'h00};
        req_valid = 4'hF;
        for (int i = 0; i < 20; i++) step(1'b0);
        req_valid = '0;
        for (int i = 0; i < 4; i++) step(1'b0);

        do_reset();
        req_phase = {8'h11, 8'h22, 8'h33, 8'h44};
        req_valid = 4'b0010;
        #1 check("fair_ch1_first", 32'(req_ready), 32'b0010);
        step(1'b0);
        req_valid = 4'b0011;
        #1 check("fair_ch0_after_ch1", 32'(req_ready), 32'b0001);
        step(1'b0);
        #1 check("fair_ch1_again", 32'(req_ready), 32'b0010);
        step(1'b0);
        #1 check("fair_ch0_again", 32'(req_ready), 32'b0001);
        step(1'b0);
        req_valid = '0;
        for (int i = 0; i < 4; i++) step(1'b0);

        do_reset();
        req_phase = {8'h00, 8'h90, 8'h50, 8'h10};
        req_valid = 4'b0111;
        step(1'b0);
        step(1'b0);
        step(1'b1);
        req_valid = '0;
        step(1'b0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0);
        req_valid = 4'b1000;
        req_phase[31:24] = 8'h41;
        #1 check("post_reset_ch3_ready", 32'(req_ready), 32'b1000);
        step(1'b0);
        req_valid = '0;
        step(1'b0);
        step(1'b0);
        check("post_reset_rsp_valid", 32'(rsp_valid), 32'd1);
        check("post_reset_rsp_ch", 32'(rsp_ch), 32'd3);
        check("post_reset_rsp_data", 32'(rsp_data), 32'(golden(8'h41)));
        do_reset();
        req_valid = 4'b1010;
        #1 check("post_reset_lowest", 32'(req_ready), 32'b0010);
        step(1'b0);
        req_valid = '0;
        for (int i = 0; i < 4; i++) step(1'b0);

        req_valid = 4'b0010;
        for (int p = 0; p < 256; p++) begin
            req_phase[15:8] = 8'(p);
            step(1'b0);
        end
        req_valid = '0;
        for (int i = 0; i < 4; i++) step(1'b0);

        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b0;
                step(1'b0);
                rst = 1'b1;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (!(req_valid[c] && mdl_gnt != c)) begin
                    req_valid[c] = ($urandom_range(0, 99) < 55);
                    req_phase[c*8 +: 8] = 8'($urandom);
                end
            end
            step(1'b0);
        end
        req_valid = '0;
        for (int i = 0; i < 4; i++) step(1'b0);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
